alu: RTL and testbench

8-bit, two-operand arithmetic/logic unit with a 2-bit operation select and registered result and flag outputs. It is a leaf datapath block. Each clock it computes one of add, subtract, AND or OR on `a` and `b`, and presents the result with carry/borrow flags one cycle later. It has no handshake: every clock edge captures a new operation.

---
 rtl/alu.sv | 89 ++++++++
 tb/tb_alu.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: 8-bit two-operand add/sub/and/or unit with a single registered
// output stage holding the result and the carry/borrow flags.
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] choice,
  output logic [7:0] c,
  output logic       cout,
  output logic       borrow
);

  localparam int DATA_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Operands are unsigned; both are zero-extended by one bit so that the
  // ninth bit carries the add carry or the subtract borrow.
  function automatic logic unsigned [DATA_W:0] add_ext(
    input logic unsigned [DATA_W-1:0] x,
    input logic unsigned [DATA_W-1:0] y
  );
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Bit DATA_W of the extended difference is set exactly when x < y.
  function automatic logic unsigned [DATA_W:0] sub_ext(
    input logic unsigned [DATA_W-1:0] x,
    input logic unsigned [DATA_W-1:0] y
  );
    return {1'b0, x} - {1'b0, y};
  endfunction

  logic unsigned [DATA_W:0]   sum_p0;
  logic unsigned [DATA_W:0]   diff_p0;
  logic unsigned [DATA_W-1:0] res_p0;
  logic                       cout_p0;
  logic                       borrow_p0;

  logic unsigned [DATA_W-1:0] res_p1;
  logic                       cout_p1;
  logic                       borrow_p1;

  // Stage p0: combinational decode of the selected operation; flags not
  // owned by the operation are forced low rather than held.
  always_comb begin
    sum_p0    = add_ext(a, b);
    diff_p0   = sub_ext(a, b);
    res_p0    = '0;
    cout_p0   = 1'b0;
    borrow_p0 = 1'b0;
    case (choice)
      OP_ADD: begin
        res_p0  = sum_p0[DATA_W-1:0];
        cout_p0 = sum_p0[DATA_W];
      end
      OP_SUB: begin
        res_p0    = diff_p0[DATA_W-1:0];
        borrow_p0 = diff_p0[DATA_W];
      end
      OP_AND:  res_p0 = a & b;
      OP_OR:   res_p0 = a | b;
      default: res_p0 = '0;
    endcase
  end

  // Stage p1: the single output register; reset clears the visible result
  // and flags at once, discarding whatever was in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_p1    <= '0;
      cout_p1   <= 1'b0;
      borrow_p1 <= 1'b0;
    end else begin
      res_p1    <= res_p0;
      cout_p1   <= cout_p0;
      borrow_p1 <= borrow_p0;
    end
  end

  assign c      = res_p1;
  assign cout   = cout_p1;
  assign borrow = borrow_p1;

endmodule

// File: tb/tb_alu.sv
// tb_alu: table-driven directed vectors, reset corner sequences and a
// randomized run against an arithmetic reference model.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] choice;
  logic [7:0] c;
  logic       cout;
  logic       borrow;

  int compared;
  int mismatched;

  alu dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .choice (choice),
    .c      (c),
    .cout   (cout),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] ch;
    logic [7:0] ec;
    logic       ecout;
    logic       eborrow;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [7:0] ec,
                       input logic eco, input logic ebo);
    compared++;
    if (c !== ec || cout !== eco || borrow !== ebo) begin
      mismatched++;
      $display("FAIL %s: got c=%02h cout=%0b borrow=%0b, want c=%02h cout=%0b borrow=%0b",
               nm, c, cout, borrow, ec, eco, ebo);
    end
  endtask

  // Reference: plain integer arithmetic on the operation rules.
  task automatic model(input logic [7:0] x, input logic [7:0] y, input logic [1:0] ch,
                       output logic [7:0] ec, output logic eco, output logic ebo);
    int ix, iy, r;
    ix = x; iy = y;
    eco = 1'b0; ebo = 1'b0;
    case (ch)
      2'd0: begin r = ix + iy; ec = 8'(r % 256); eco = (r > 255); end
      2'd1: begin r = ix - iy; ec = 8'((r + 256) % 256); ebo = (ix < iy); end
      2'd2: ec = x & y;
      default: ec = x | y;
    endcase
  endtask

  // Drive at the falling edge, check 1 time unit after the capturing edge.
  task automatic apply(input string nm, input logic [7:0] x, input logic [7:0] y,
                       input logic [1:0] ch, input logic [7:0] ec,
                       input logic eco, input logic ebo);
    @(negedge clk);
    a = x; b = y; choice = ch;
    @(posedge clk);
    #1;
    check(nm, ec, eco, ebo);
  endtask

  initial begin
    logic [7:0] ec, ra, rb;
    logic       eco, ebo;
    logic [1:0] rch;

    compared = 0;
    mismatched = 0;
    rst = 1'b1; a = 8'hAA; b = 8'h55; choice = 2'b00;

    vecs.push_back('{"add_carry",  8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{"add_plain",  8'h12, 8'h34, 2'b00, 8'h46, 1'b0, 1'b0});
    vecs.push_back('{"sub_borrow", 8'h05, 8'h07, 2'b01, 8'hFE, 1'b0, 1'b1});
    vecs.push_back('{"sub_equal",  8'h80, 8'h80, 2'b01, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{"and",        8'hF0, 8'h3C, 2'b10, 8'h30, 1'b0, 1'b0});
    vecs.push_back('{"or",         8'hF0, 8'h3C, 2'b11, 8'hFC, 1'b0, 1'b0});
    vecs.push_back('{"b2b_add",    8'hC8, 8'h64, 2'b00, 8'h2C, 1'b1, 1'b0});
    vecs.push_back('{"b2b_sub",    8'hC8, 8'h64, 2'b01, 8'h64, 1'b0, 1'b0});
    vecs.push_back('{"b2b_and",    8'hC8, 8'h64, 2'b10, 8'h40, 1'b0, 1'b0});
    vecs.push_back('{"b2b_or",     8'hC8, 8'h64, 2'b11, 8'hEC, 1'b0, 1'b0});
    vecs.push_back('{"sub_zero_b", 8'h00, 8'h01, 2'b01, 8'hFF, 1'b0, 1'b1});
    vecs.push_back('{"add_max",    8'hFF, 8'hFF, 2'b00, 8'hFE, 1'b1, 1'b0});

    // Reset held across clock edges
    repeat (2) @(posedge clk);
    #1;
    check("reset_init", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].ch,
            vecs[i].ec, vecs[i].ecout, vecs[i].eborrow);

    // Flag clears the cycle after the owning op goes away
    apply("carry_set", 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b0);
    apply("carry_clr", 8'hFF, 8'h01, 2'b11, 8'hFF, 1'b0, 1'b0);
    apply("borrow_set", 8'h01, 8'h02, 2'b01, 8'hFF, 1'b0, 1'b1);
    apply("borrow_clr", 8'h01, 8'h02, 2'b10, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset between edges with non-zero outputs present
    apply("pre_reset", 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b0);
    apply("pre_reset2", 8'h12, 8'h34, 2'b11, 8'h36, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("reset_async", 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a = 8'(k * 37 + 200); b = 8'(k * 91 + 99); choice = 2'(k);
      @(posedge clk);
      #1;
      check("reset_hold", 8'h00, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    a = 8'hFF; b = 8'h01; choice = 2'b00;
    @(posedge clk);
    #1;
    check("post_reset", 8'h00, 1'b1, 1'b0);

    // Randomized run against the reference model
    for (int n = 0; n < 20000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rch = 2'($urandom_range(0, 3));
      if (n % 64 == 0) rb = ra;
      model(ra, rb, rch, ec, eco, ebo);
      apply("random", ra, rb, rch, ec, eco, ebo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
